csa_serial_add_ctrl: RTL and testbench

//  Multi-cycle sequencer that computes WIDTH-bit a+b+cin on a single 4-bit

---
 rtl/csa_serial_add_ctrl.sv | 179 +++++++++++++++++
 tb/tb_csa_serial_add_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_serial_add_ctrl.sv
// csa_serial_add_ctrl
// Computes WIDTH-bit a+b+cin on one shared 4-bit carry-skip adder slice,
// one nibble per clock, LSB nibble first. Valid/ready handshakes on both
// the operand and result sides.
// Optional build macro: CSA_SKIP_STATS_EN adds the skip_cnt output, which
// counts the nibbles of the current operation that took the skip path.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1; sum/cout hold last result
// RUN   | one nibble added per cycle, exactly CHUNKS cycles
// DONE  | result presented (out_valid=1) until consumer takes it
module csa_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CSA_SKIP_STATS_EN
    ,
    output logic [$clog2(WIDTH/4+1)-1:0] skip_cnt
`endif
);

    localparam int CHUNKS = WIDTH / 4;
    localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic              accept;
    logic              last_chunk;
    logic [3:0]        nib_a, nib_b;
    logic [3:0]        slice_sum;
    logic              slice_co;
    logic              slice_skip;

    assign accept     = in_valid && (state_q == ST_IDLE);
    assign last_chunk = (idx_q == IDXW'(CHUNKS - 1));
    assign nib_a      = a_q[{idx_q, 2'b00} +: 4];
    assign nib_b      = b_q[{idx_q, 2'b00} +: 4];

    // 4-bit slice: ripple of full adders, bypassed when every bit propagates
    always_comb begin
        logic [3:0] p;
        logic [3:0] g;
        logic       c;
        p = nib_a ^ nib_b;
        g = nib_a & nib_b;
        c = carry_q;
        slice_sum = 4'd0;
        for (int i = 0; i < 4; i++) begin
            slice_sum[i] = p[i] ^ c;
            c            = g[i] | (p[i] & c);
        end
        slice_skip = &p;
        slice_co   = slice_skip ? carry_q : c;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            ST_RUN:  if (last_chunk) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the registered state only
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    end

    // Datapath next values: latch on accept, one nibble per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
        end else if (state_q == ST_RUN) begin
            sum_d[{idx_q, 2'b00} +: 4] = slice_sum;
            carry_d = slice_co;
            idx_d   = idx_q + IDXW'(1);
            if (last_chunk) begin
                cout_d = slice_co;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef CSA_SKIP_STATS_EN
    localparam int SKW = $clog2(CHUNKS + 1);

    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;

    // Skip statistics: cleared on accept, counts skipping nibbles in RUN
    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (accept) begin
            skip_cnt_d = '0;
        end else if ((state_q == ST_RUN) && slice_skip) begin
            skip_cnt_d = skip_cnt_q + SKW'(1);
        end
    end

    // Skip statistics register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt_q <= '0;
        end else begin
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Bench for csa_serial_add_ctrl (WIDTH=16): directed cases plus randomized
// operations compared with a plain-arithmetic reference model.
module tb_csa_serial_add_ctrl;

    localparam int WIDTH = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              busy;
`ifdef CSA_SKIP_STATS_EN
    logic [2:0]        skip_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    csa_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CSA_SKIP_STATS_EN
        ,
        .skip_cnt  (skip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: plain arithmetic
    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    function automatic int ref_skips(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p;
        int n;
        p = x ^ y;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (((p >> (4 * k)) & 16'hF) == 16'hF) n++;
        end
        return n;
    endfunction

    // one complete operation from IDLE, optional DONE stall with ignored pulses
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input int stall);
        logic [16:0] exp;
        int lat;
        int exp_skips;
        exp       = ref_sum(ta, tb_, tc);
        exp_skips = ref_skips(ta, tb_);
        chk("idle_in_ready", in_ready, 1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            if (!out_valid) lat++;
            else break;
        end
        chk("latency", lat, 4);
        chk("sum", sum, exp[15:0]);
        chk("cout", cout, exp[16]);
        chk("done_in_ready", in_ready, 0);
`ifdef CSA_SKIP_STATS_EN
        chk("skip_cnt", skip_cnt, exp_skips);
`endif
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_sum", sum, exp[15:0]);
            chk("stall_cout", cout, exp[16]);
            chk("stall_in_ready", in_ready, 0);
`ifdef CSA_SKIP_STATS_EN
            chk("stall_skip_cnt", skip_cnt, exp_skips);
`endif
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_busy", busy, 0);
        chk("idle_sum_hold", sum, exp[15:0]);
        chk("idle_cout_hold", cout, exp[16]);
    endtask

    logic [16:0] q_exp[$];
    int          q_skp[$];

    initial begin
        int last_acc;
        int done_cnt;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef CSA_SKIP_STATS_EN
        chk("rst_skip_cnt", skip_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();

        // directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h0F0F, 16'hF0F0, 1'b1, 0);
        run_op(16'hA5C3, 16'h7E19, 1'b1, 10);

        // random ops with random stalls
        for (int i = 0; i < 20; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // reset during second RUN cycle
        a = 16'hBEEF; b = 16'h1357; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("midrst_in_ready", in_ready, 1);
        run_op(16'h0001, 16'h0001, 1'b0, 0);

        // streaming: out_ready tied high, in_valid always high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_acc  = -1;
        done_cnt  = 0;
        cyc       = 0;
        while (done_cnt < 1000 && cyc < 7000) begin
            if (out_valid) begin
                if (q_exp.size() == 0) begin
                    chk("stream_unexpected_result", 1, 0);
                end else begin
                    logic [16:0] e;
                    int          sk;
                    e  = q_exp.pop_front();
                    sk = q_skp.pop_front();
                    chk("stream_sum", {15'd0, cout, sum}, {15'd0, e});
`ifdef CSA_SKIP_STATS_EN
                    chk("stream_skip_cnt", skip_cnt, sk);
`endif
                end
                done_cnt++;
            end
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            if (in_ready) begin
                q_exp.push_back(ref_sum(a, b, cin));
                q_skp.push_back(ref_skips(a, b));
                if (last_acc >= 0) chk("stream_spacing", cyc - last_acc, 6);
                last_acc = cyc;
            end
            tick();
            cyc++;
        end
        chk("stream_done_count", done_cnt, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
